mxn_iterative_shifter: RTL

MXN_ITERATIVE_SHIFTER -- requirements
Module: mxn_iterative_shifter

---
 rtl/mxn_iterative_shifter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/mxn_iterative_shifter.sv
// Multi-lane iterative shifter: SETS independent lanes of WIDTH bits, shifted
// one bit per cycle by a common effective count, with valid/ready handshakes.
//
// state | meaning
// IDLE  | waiting for a request, in_ready high
// SHIFT | stepping every lane by one bit per cycle until the count is spent
// DONE  | result presented, held until the consumer takes it
module mxn_iterative_shifter #(
  parameter int WIDTH = 4,
  parameter int SETS  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SETS*WIDTH-1:0] in_packed,
  input  logic                  shift_dir,
  input  logic [WIDTH-1:0]      shift_amt,
  input  logic [1:0]            mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SETS*WIDTH-1:0] out_packed,
  output logic                  err
);

  if (WIDTH < 2 || SETS < 1) begin : g_param_chk
    $error("mxn_iterative_shifter: WIDTH must be >= 2 and SETS >= 1");
  end

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [1:0] MODE_LOG = 2'b00;
  localparam logic [1:0] MODE_ARI = 2'b01;
  localparam logic [1:0] MODE_ROT = 2'b10;

  // shift_amt can always represent WIDTH, since 2**WIDTH > WIDTH
  localparam logic [WIDTH-1:0] WIDTH_C = WIDTH[WIDTH-1:0];

  state_t                state_q, state_d;
  logic [SETS*WIDTH-1:0] data_q, data_d;
  logic                  dir_q, dir_d;
  logic [1:0]            mode_q, mode_d;
  logic [WIDTH-1:0]      cnt_q, cnt_d;
  logic                  err_q, err_d;

  logic [WIDTH-1:0]      n_eff;
  logic [SETS*WIDTH-1:0] step;
  logic [WIDTH-1:0]      lane;
  logic                  fill;
  logic                  accept;

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign out_packed = data_q;
  assign err        = err_q;
  assign accept     = in_valid && in_ready;

  // Effective count: saturate for shifts, wrap for rotate, none for reserved
  always_comb begin
    n_eff = '0;
    case (mode)
      MODE_LOG, MODE_ARI: n_eff = (shift_amt > WIDTH_C) ? WIDTH_C : shift_amt;
      MODE_ROT:           n_eff = shift_amt % WIDTH_C;
      default:            n_eff = '0;
    endcase
  end

  // One-bit step applied to every lane independently
  always_comb begin
    step = data_q;
    lane = '0;
    fill = 1'b0;
    for (int i = 0; i < SETS; i++) begin
      lane = data_q[i*WIDTH +: WIDTH];
      if (dir_q) begin
        case (mode_q)
          MODE_ARI: fill = lane[WIDTH-1];
          MODE_ROT: fill = lane[0];
          default:  fill = 1'b0;
        endcase
        step[i*WIDTH +: WIDTH] = {fill, lane[WIDTH-1:1]};
      end else begin
        fill = (mode_q == MODE_ROT) ? lane[WIDTH-1] : 1'b0;
        step[i*WIDTH +: WIDTH] = {lane[WIDTH-2:0], fill};
      end
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    dir_d   = dir_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          data_d  = in_packed;
          dir_d   = shift_dir;
          mode_d  = mode;
          cnt_d   = n_eff;
          err_d   = (mode == 2'b11);
          state_d = (n_eff != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        data_d = step;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == WIDTH_C'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      dir_q   <= 1'b0;
      mode_q  <= MODE_LOG;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      dir_q   <= dir_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

endmodule
